// File: rtl/usb_rx_pkg.sv
`default_nettype none
// ============================================================================
// usb_rx_pkg : receiver state type and idle (J) line-state constants
// Revision   : 1.0
// ============================================================================
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        EOP    = 2'd2
    } rx_state_t;

    localparam logic J_DP = 1'b1;
    localparam logic J_DM = 1'b0;

    function automatic logic is_se0(input logic dp, input logic dm);
        return !dp && !dm;
    endfunction

    function automatic logic is_j(input logic dp, input logic dm);
        return (dp == J_DP) && (dm == J_DM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_high.sv
`default_nettype none
// ============================================================================
// sync_high : two-flop synchronizer whose output resets high
// Revision  : 1.0
// ============================================================================
module sync_high (
    input  logic clk,
    input  logic n_rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule
`default_nettype wire

// File: rtl/sync_low.sv
`default_nettype none
// ============================================================================
// sync_low : two-flop synchronizer whose output resets low
// Revision : 1.0
// ============================================================================
module sync_low (
    input  logic clk,
    input  logic n_rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule
`default_nettype wire

// File: rtl/usb_bit_timer.sv
`default_nettype none
// ============================================================================
// usb_bit_timer : bit-period counter, realigned on every D+ transition
// Revision      : 1.0
// ============================================================================
module usb_bit_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic dp_edge,
    output logic sample
);

    localparam int               CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_POINT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A transition coinciding with the sample point wins: no sample, restart.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        if (clear || dp_edge || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
        sample = !clear && !dp_edge && (cnt_q == CNT_SAMPLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_rx_sampler.sv
`default_nettype none
// ============================================================================
// usb_rx_sampler : USB full-speed receive front-end (sync, bit timing, NRZI, EOP)
// Revision       : 1.0
// ============================================================================
module usb_rx_sampler
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus_raw,
    input  logic d_minus_raw,
    input  logic rcv_enable,
    output logic shift_en,
    output logic d_orig,
    output logic eop,
    output logic rx_active
);

    logic      d_plus_sync;
    logic      d_minus_sync;
    logic      dp_edge;
    logic      timer_clear;
    logic      sample;
    logic      line_se0;
    logic      line_j;
    logic      nrzi_bit;

    logic      dp_prev_q,   dp_prev_d;
    rx_state_t state_q,     state_d;
    logic      last_bit_q,  last_bit_d;
    logic      shift_en_q,  shift_en_d;
    logic      d_orig_q,    d_orig_d;
    logic      eop_q,       eop_d;
    logic      rx_active_q, rx_active_d;

    sync_high u_sync_dp (
        .clk      (clk),
        .n_rst    (n_rst),
        .async_in (d_plus_raw),
        .sync_out (d_plus_sync)
    );

    sync_low u_sync_dm (
        .clk      (clk),
        .n_rst    (n_rst),
        .async_in (d_minus_raw),
        .sync_out (d_minus_sync)
    );

    assign dp_edge     = d_plus_sync ^ dp_prev_q;
    assign timer_clear = (state_q == IDLE) || !rcv_enable;

    usb_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SAMPLE_POINT (SAMPLE_POINT)
    ) u_bit_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (timer_clear),
        .dp_edge (dp_edge),
        .sample  (sample)
    );

    assign line_se0 = is_se0(d_plus_sync, d_minus_sync);
    assign line_j   = is_j(d_plus_sync, d_minus_sync);
    // NRZI: no change on the line decodes as 1.
    assign nrzi_bit = (d_plus_sync == last_bit_q);

    always_comb begin
        dp_prev_d   = d_plus_sync;
        state_d     = state_q;
        last_bit_d  = last_bit_q;
        shift_en_d  = 1'b0;
        d_orig_d    = d_orig_q;
        eop_d       = 1'b0;
        rx_active_d = (state_q != IDLE);

        if (!rcv_enable) begin
            state_d    = IDLE;
            last_bit_d = J_DP;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dp_edge) begin
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (sample) begin
                        shift_en_d = 1'b1;
                        if (line_se0) begin
                            state_d  = EOP;
                            eop_d    = 1'b1;
                            d_orig_d = 1'b0;
                        end else begin
                            d_orig_d   = nrzi_bit;
                            last_bit_d = d_plus_sync;
                        end
                    end
                end
                EOP: begin
                    if (sample) begin
                        if (line_se0) begin
                            eop_d = 1'b1;
                        end else if (line_j) begin
                            state_d    = IDLE;
                            last_bit_d = J_DP;
                        end else begin
                            state_d    = ACTIVE;
                            shift_en_d = 1'b1;
                            d_orig_d   = nrzi_bit;
                            last_bit_d = d_plus_sync;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_prev_q   <= 1'b1;
            state_q     <= IDLE;
            last_bit_q  <= 1'b1;
            shift_en_q  <= 1'b0;
            d_orig_q    <= 1'b1;
            eop_q       <= 1'b0;
            rx_active_q <= 1'b0;
        end else begin
            dp_prev_q   <= dp_prev_d;
            state_q     <= state_d;
            last_bit_q  <= last_bit_d;
            shift_en_q  <= shift_en_d;
            d_orig_q    <= d_orig_d;
            eop_q       <= eop_d;
            rx_active_q <= rx_active_d;
        end
    end

    assign shift_en  = shift_en_q;
    assign d_orig    = d_orig_q;
    assign eop       = eop_q;
    assign rx_active = rx_active_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_sampler.sv
`default_nettype none
// ============================================================================
// tb_usb_rx_sampler : randomized line-level stimulus against a bit-timing model
// Revision          : 1.0
// ============================================================================
module tb_usb_rx_sampler;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic d_plus_raw = 1'b1;
    logic d_minus_raw = 1'b0;
    logic rcv_enable = 1'b0;
    logic shift_en;
    logic d_orig;
    logic eop;
    logic rx_active;

    usb_rx_sampler #(
        .CLKS_PER_BIT (8),
        .SAMPLE_POINT (3)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .d_plus_raw  (d_plus_raw),
        .d_minus_raw (d_minus_raw),
        .rcv_enable  (rcv_enable),
        .shift_en    (shift_en),
        .d_orig      (d_orig),
        .eop         (eop),
        .rx_active   (rx_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        bit          se;
        bit          ep;
        bit          d;
    } exp_t;

    localparam int LJ   = 0;
    localparam int LK   = 1;
    localparam int LSE0 = 2;
    localparam int BIT_CLKS = 8;
    localparam int SAMPLE_OFS = 4;   // raw index after a transition whose value gets sampled

    exp_t        exp_q[$];
    bit          plan_dp[$];
    bit          plan_dm[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          exp_dorig = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
    endtask

    task automatic add_seg(input int kind, input int len);
        for (int i = 0; i < len; i++) begin
            plan_dp.push_back(kind == LJ);
            plan_dm.push_back(kind == LK);
        end
    endtask

    // Line-level model: every D+ transition starts a bit window; the line is
    // sampled SAMPLE_OFS raw cycles later and every BIT_CLKS after that, as long
    // as the next transition has not yet arrived. Strobe appears 2 edges later.
    task automatic model_push(input int unsigned t0, input int abort_at);
        int   tr[$];
        int   n;
        int   nxt;
        int   st;          // 0 idle, 1 receiving data, 2 after SE0
        bit   last;
        bit   prev;
        bit   dp, dm, se, ep, d;
        exp_t e;
        n = plan_dp.size();
        prev = 1'b1;
        for (int j = 0; j < n; j++) begin
            if (plan_dp[j] != prev) tr.push_back(j);
            prev = plan_dp[j];
        end
        st = 0;
        last = 1'b1;
        for (int m = 0; m < tr.size(); m++) begin
            nxt = (m + 1 < tr.size()) ? tr[m+1] : n;
            if (st == 0) st = 1;
            for (int s = tr[m] + SAMPLE_OFS; s + 1 <= nxt; s += BIT_CLKS) begin
                if (st == 0) break;
                dp = plan_dp[s];
                dm = plan_dm[s];
                se = 1'b0; ep = 1'b0; d = 1'b0;
                if (!dp && !dm) begin
                    ep = 1'b1;
                    if (st == 1) begin se = 1'b1; d = 1'b0; st = 2; end
                end else if (st == 2 && dp && !dm) begin
                    st = 0; last = 1'b1;
                end else begin
                    se = 1'b1; d = (dp == last); last = dp; st = 1;
                end
                if ((se || ep) && (abort_at < 0 || t0 + s + 2 <= t0 + abort_at - 1)) begin
                    e.cyc = t0 + s + 2; e.se = se; e.ep = ep; e.d = d;
                    exp_q.push_back(e);
                    if (se) exp_dorig = d;
                end
            end
        end
    endtask

    // Drive the plan one raw value per clock; optionally abort at a plan index
    // by reset (kind 1) or by dropping rcv_enable (kind 2).
    task automatic drive_plan(input int abort_at, input int abort_kind, input bit chk_start);
        int unsigned t0;
        int          n;
        @(negedge clk);
        t0 = cyc + 1;
        model_push(t0, abort_at);
        n = plan_dp.size();
        for (int j = 0; j < n; j++) begin
            if (j > 0) @(negedge clk);
            if (chk_start && j == 3) chk("rx_active_before_E3", rx_active, 0);
            if (chk_start && j == 4) chk("rx_active_at_E3", rx_active, 1);
            if (j == abort_at) begin
                d_plus_raw = 1'b1;
                d_minus_raw = 1'b0;
                if (abort_kind == 1) begin
                    n_rst = 1'b0;
                    #1;
                    chk("rst_mid_shift_en", shift_en, 0);
                    chk("rst_mid_eop", eop, 0);
                    chk("rst_mid_rx_active", rx_active, 0);
                    chk("rst_mid_d_orig", d_orig, 1);
                    exp_dorig = 1'b1;
                    repeat (4) @(negedge clk);
                    n_rst = 1'b1;
                end else begin
                    rcv_enable = 1'b0;
                    repeat (3) @(negedge clk);
                    chk("dis_rx_active", rx_active, 0);
                    chk("dis_shift_en", shift_en, 0);
                    chk("dis_eop", eop, 0);
                    repeat (2) @(negedge clk);
                    rcv_enable = 1'b1;
                end
                break;
            end
            d_plus_raw = plan_dp[j];
            d_minus_raw = plan_dm[j];
        end
        plan_dp.delete();
        plan_dm.delete();
    endtask

    task automatic end_of_packet_checks(input string tag);
        chk({tag, "_rx_active_idle"}, rx_active, 0);
        chk({tag, "_d_orig_held"}, d_orig, exp_dorig);
    endtask

    // Scoreboard monitor: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (shift_en === 1'b1 || eop === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, shift_en, eop}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("shift_en", shift_en, e.se);
                chk("eop", eop, e.ep);
                if (e.se) chk("d_orig", d_orig, e.d);
            end
        end
    end

    initial begin
        int nbits;
        n_rst = 1'b0;
        rcv_enable = 1'b1;
        d_plus_raw = 1'b1;
        d_minus_raw = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_shift_en", shift_en, 0);
        chk("reset_eop", eop, 0);
        chk("reset_rx_active", rx_active, 0);
        chk("reset_d_orig", d_orig, 1);
        n_rst = 1'b1;

        repeat (100) @(negedge clk);
        chk("idle_rx_active", rx_active, 0);
        chk("idle_d_orig", d_orig, 1);

        // K,K,J,J,J then SE0 and back to J
        add_seg(LK, 8); add_seg(LK, 8);
        add_seg(LJ, 8); add_seg(LJ, 8); add_seg(LJ, 8);
        add_seg(LSE0, 16); add_seg(LJ, 30);
        drive_plan(-1, 0, 1'b1);
        end_of_packet_checks("kkjjj");

        // one short (7-cycle) bit forces a resync
        add_seg(LK, 8); add_seg(LJ, 7); add_seg(LK, 8); add_seg(LJ, 8);
        add_seg(LSE0, 16); add_seg(LJ, 30);
        drive_plan(-1, 0, 1'b0);
        end_of_packet_checks("early_edge");

        // reset while cnt == 5
        add_seg(LK, 20);
        drive_plan(8, 1, 1'b0);
        repeat (20) @(negedge clk);
        chk("after_rst_rx_active", rx_active, 0);
        chk("after_rst_d_orig", d_orig, 1);

        // receiver disabled while cnt == 5
        add_seg(LK, 20);
        drive_plan(8, 2, 1'b0);
        repeat (20) @(negedge clk);
        chk("after_dis_rx_active", rx_active, 0);

        // restart plus randomized packets with jittered bit lengths
        for (int p = 0; p < 14; p++) begin
            nbits = $urandom_range(3, 16);
            add_seg(LK, $urandom_range(7, 9));
            for (int b = 1; b < nbits; b++) begin
                add_seg(($urandom_range(0, 1) == 0) ? LJ : LK, $urandom_range(7, 9));
            end
            add_seg(LSE0, $urandom_range(14, 18));
            add_seg(LJ, 30);
            drive_plan(-1, 0, 1'b0);
            end_of_packet_checks("rand");
        end

        repeat (10) @(negedge clk);
        chk("pending_expected", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
